gb_lcd_capture: RTL and testbench

- Samples the Game Boy LCD pixel bus (2-bit data, pixel clock, line and frame syncs) in the `clk` domain.
- Writes each 160x144 frame, one pixel per word, into the 2-bit framebuffer RAM at linear addresses 0..23039 (row-major, `y*160+x`).
- Sits directly upstream of the VGA scan-out, which reads the same RAM through its own port.
- Provides a frame-done strobe for the downstream AI logic.

---
 rtl/gb_lcd_capture.sv | 170 +++++++++++++++++
 tb/tb_gb_lcd_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture into a linear 2-bit framebuffer (row-major, y*H_PIXELS+x).
// Optional line-length checking is compiled in with `define LINE_CHECK_EN (adds line_err).
module gb_lcd_capture #(
  parameter int H_PIXELS    = 160,
  parameter int V_LINES     = 144,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              lcd_cp,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic [1:0]        lcd_data,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_d,
  output logic              fb_we,
  output logic              frame_done,
  output logic              busy
`ifdef LINE_CHECK_EN
  ,
  output logic              line_err
`endif
);

  localparam int X_W = $clog2(H_PIXELS + 2);
  localparam int Y_W = $clog2(V_LINES + 1);
  localparam logic [X_W-1:0] X_FULL = X_W'(H_PIXELS);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cp_sync_q, hs_sync_q, vs_sync_q;
  logic [1:0]             dat_sync_q [SYNC_STAGES];
  logic                   cp_hist_q, hs_hist_q, vs_hist_q;
  logic [X_W-1:0]         x_q, x_d, x_inc;
  logic [Y_W-1:0]         y_q, y_d;
  logic [ADDR_W-1:0]      lb_q, lb_d;
  logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
  logic [1:0]             fb_d_q, fb_d_d;
  logic                   fb_we_q, fb_we_d;
  logic                   fd_q, fd_d;
  logic                   pix_edge, hs_edge, vs_edge, write_ok;
`ifdef LINE_CHECK_EN
  logic                   le_q, le_d;
  logic [X_W-1:0]         x_line_end;
`endif

  assign pix_edge = cp_hist_q & ~cp_sync_q[SYNC_STAGES-1];
  assign hs_edge  = ~hs_hist_q & hs_sync_q[SYNC_STAGES-1];
  assign vs_edge  = ~vs_hist_q & vs_sync_q[SYNC_STAGES-1];
  assign write_ok = pix_edge && (x_q < X_FULL);
  // x keeps counting one past the line width so over-long lines stay distinguishable.
  assign x_inc    = (x_q <= X_FULL) ? x_q + X_W'(1) : x_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    lb_d      = lb_q;
    fb_addr_d = fb_addr_q;
    fb_d_d    = fb_d_q;
    fb_we_d   = 1'b0;
    fd_d      = 1'b0;
`ifdef LINE_CHECK_EN
    le_d       = le_q;
    x_line_end = pix_edge ? x_inc : x_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture_en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_edge) begin
          x_d     = '0;
          y_d     = '0;
          lb_d    = '0;
          state_d = CAPTURE;
`ifdef LINE_CHECK_EN
          le_d    = 1'b0;
`endif
        end
      end
      CAPTURE: begin
        if (vs_edge) begin
          x_d  = '0;
          y_d  = '0;
          lb_d = '0;
        end else begin
          // A pixel coinciding with the line latch still belongs to the ending line.
          if (write_ok) begin
            fb_we_d   = 1'b1;
            fb_addr_d = lb_q + ADDR_W'(x_q);
            fb_d_d    = dat_sync_q[SYNC_STAGES-1];
          end
          if (hs_edge) begin
            x_d  = '0;
            lb_d = lb_q + ADDR_W'(H_PIXELS);
            y_d  = y_q + Y_W'(1);
`ifdef LINE_CHECK_EN
            if (x_line_end != X_FULL) le_d = 1'b1;
`endif
            if (y_q == Y_LAST) begin
              fd_d    = 1'b1;
              state_d = IDLE;
            end
          end else if (pix_edge) begin
            x_d = x_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cp_sync_q <= '0;
      hs_sync_q <= '0;
      vs_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) dat_sync_q[i] <= 2'b00;
      cp_hist_q <= 1'b0;
      hs_hist_q <= 1'b0;
      vs_hist_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      lb_q      <= '0;
      fb_addr_q <= '0;
      fb_d_q    <= 2'b00;
      fb_we_q   <= 1'b0;
      fd_q      <= 1'b0;
`ifdef LINE_CHECK_EN
      le_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cp_sync_q <= {cp_sync_q[SYNC_STAGES-2:0], lcd_cp};
      hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], lcd_hsync};
      vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], lcd_vsync};
      dat_sync_q[0] <= lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) dat_sync_q[i] <= dat_sync_q[i-1];
      cp_hist_q <= cp_sync_q[SYNC_STAGES-1];
      hs_hist_q <= hs_sync_q[SYNC_STAGES-1];
      vs_hist_q <= vs_sync_q[SYNC_STAGES-1];
      x_q       <= x_d;
      y_q       <= y_d;
      lb_q      <= lb_d;
      fb_addr_q <= fb_addr_d;
      fb_d_q    <= fb_d_d;
      fb_we_q   <= fb_we_d;
      fd_q      <= fd_d;
`ifdef LINE_CHECK_EN
      le_q      <= le_d;
`endif
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_d       = fb_d_q;
  assign fb_we      = fb_we_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != IDLE);
`ifdef LINE_CHECK_EN
  assign line_err   = le_q;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture on a reduced 10x6 frame, with a write scoreboard
// fed by a pixel/line/frame model of the LCD capture rules.
module tb_gb_lcd_capture;
  localparam int H  = 10;
  localparam int V  = 6;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset, capture_en, lcd_cp, lcd_hsync, lcd_vsync;
  logic [1:0]  lcd_data;
  logic [14:0] fb_addr;
  logic [1:0]  fb_d;
  logic        fb_we, frame_done, busy;
`ifdef LINE_CHECK_EN
  logic        line_err;
`endif

  always #5 clk = ~clk;

  gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(15), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .lcd_cp(lcd_cp), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_data(lcd_data),
    .fb_addr(fb_addr), .fb_d(fb_d), .fb_we(fb_we), .frame_done(frame_done), .busy(busy)
`ifdef LINE_CHECK_EN
    , .line_err(line_err)
`endif
  );

  typedef struct {int a; int d;} wr_t;
  wr_t exp_q[$];
  int errors = 0, checks = 0;
  int m_state = 0, mx = 0, my = 0, exp_fd = 0, exp_le = 0;
  int wr_cnt = 0, fd_seen = 0, last_addr = -1, last_data = -1;
  int prev_we = 0, prev_addr = 0, prev_d = 0, prev_rst = 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: a frame is open (m_state 2) between an armed vsync and the last line's hsync.
  task automatic m_vsync();
    if (m_state == 2 || capture_en) begin
      if (m_state != 2) exp_le = 0;
      m_state = 2; mx = 0; my = 0;
    end
  endtask

  task automatic m_pixel(input int d);
    wr_t w;
    if (m_state == 2) begin
      if (mx < H) begin
        w.a = my * H + mx; w.d = d;
        exp_q.push_back(w);
      end
      mx++;
    end
  endtask

  task automatic m_hsync();
    if (m_state == 2) begin
      if (mx != H) exp_le = 1;
      if (my == V - 1) begin exp_fd++; m_state = 0; end
      else begin my++; mx = 0; end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pix(input int d, input bit with_hs);
    lcd_data = 2'(d); lcd_cp = 1'b1; cyc(2);
    lcd_cp = 1'b0;
    if (with_hs) lcd_hsync = 1'b1;
    m_pixel(d);
    if (with_hs) m_hsync();
    cyc(2);
    lcd_hsync = 1'b0;
  endtask

  task automatic hs();
    lcd_hsync = 1'b1; m_hsync(); cyc(2);
    lcd_hsync = 1'b0; cyc(2);
  endtask

  task automatic vs();
    lcd_vsync = 1'b1; m_vsync(); cyc(2);
    lcd_vsync = 1'b0; cyc(2);
  endtask

  task automatic line(input int y, input int n, input bit coinc);
    for (int x = 0; x < n; x++) pix((x + y) & 3, coinc && (x == n - 1));
    if (!coinc) hs();
  endtask

  task automatic frame(input bit coinc);
    vs();
    for (int y = 0; y < V; y++) line(y, H, coinc);
    cyc(4);
  endtask

  task automatic chk_le();
`ifdef LINE_CHECK_EN
    chk("line_err", int'(line_err), exp_le);
`endif
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (fb_we) begin
      chk("we_gap", prev_we, 0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", fb_addr, fb_d);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(fb_addr), e.a);
        chk("wr_data", int'(fb_d), e.d);
      end
      wr_cnt++; last_addr = int'(fb_addr); last_data = int'(fb_d);
    end else if (!reset && !prev_rst) begin
      chk("addr_hold", int'(fb_addr), prev_addr);
      chk("data_hold", int'(fb_d), prev_d);
    end
    if (frame_done) begin
      fd_seen++;
      chk("busy_at_fd", int'(busy), 0);
    end
    prev_we = int'(fb_we); prev_addr = int'(fb_addr); prev_d = int'(fb_d); prev_rst = int'(reset);
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; lcd_cp = 1'b0; lcd_hsync = 1'b0; lcd_vsync = 1'b0;
    lcd_data = 2'b00;
    cyc(3);
    chk("rst_we", int'(fb_we), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_d", int'(fb_d), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk_le();
    reset = 1'b0; cyc(2);

    // Capture disabled: traffic runs, nothing is written.
    frame(1'b0);
    chk("dis_wr", wr_cnt, 0);
    chk("dis_busy", int'(busy), 0);
    // Enable mid-frame: must wait for the next vsync.
    vs(); line(0, H, 1'b0); line(1, H, 1'b0);
    capture_en = 1'b1; cyc(2);
    chk("arm_busy", int'(busy), 1);
    for (int y = 2; y < V; y++) line(y, H, 1'b0);
    cyc(4);
    chk("arm_wr", wr_cnt, 0);
    chk("arm_fd", fd_seen, 0);
    frame(1'b0); cyc(6);
    chk("f1_wr", wr_cnt, 60);
    chk("f1_last_addr", last_addr, 59);
    chk("f1_last_data", last_data, 2);
    chk("f1_fd", fd_seen, 1);
    chk("f1_drain", exp_q.size(), 0);

    // Over-long line 1: extra pixels dropped, line 2 starts at 20.
    vs(); line(0, H, 1'b0); cyc(4); chk_le();
    line(1, 15, 1'b0);
    pix(2, 1'b0); cyc(4);
    chk("long_next_addr", last_addr, 20);
    chk("long_next_data", last_data, 2);
    for (int x = 1; x < H; x++) pix((x + 2) & 3, 1'b0);
    hs();
    for (int y = 3; y < V; y++) line(y, H, 1'b0);
    cyc(6);
    chk("f2_fd", fd_seen, 2);
    chk("f2_wr", wr_cnt, 120);
    chk_le();

    // vsync mid-line restarts the frame without frame_done.
    vs();
    for (int y = 0; y < 3; y++) line(y, H, 1'b0);
    for (int x = 0; x < 4; x++) pix((x + 3) & 3, 1'b0);
    vs(); pix(3, 1'b0); cyc(4);
    chk("restart_addr", last_addr, 0);
    chk("restart_data", last_data, 3);
    chk("restart_fd", fd_seen, 2);
    for (int x = 1; x < H; x++) pix(x & 3, 1'b0);
    hs();
    for (int y = 1; y < V; y++) line(y, H, 1'b0);
    cyc(6);
    chk("f3_fd", fd_seen, 3);
    chk("f3_wr", wr_cnt, 214);
    chk_le();

    // Last pixel of each line lands on the same cycle as the hsync edge.
    frame(1'b1); cyc(6);
    chk("f4_fd", fd_seen, 4);
    chk("f4_wr", wr_cnt, 274);
    chk("f4_last_addr", last_addr, 59);
    chk("f4_last_data", last_data, 2);
    chk("f4_drain", exp_q.size(), 0);
    chk_le();

    // Reset mid-frame abandons it.
    vs();
    for (int y = 0; y < 3; y++) line(y, H, 1'b0);
    for (int x = 0; x < 7; x++) pix((x + 3) & 3, 1'b0);
    cyc(6);
    chk("pre_rst_drain", exp_q.size(), 0);
    chk("pre_rst_addr", last_addr, 36);
    reset = 1'b1; m_state = 0; exp_le = 0;
    cyc(1);
    chk("mid_rst_we", int'(fb_we), 0);
    chk("mid_rst_addr", int'(fb_addr), 0);
    chk("mid_rst_d", int'(fb_d), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fd", int'(frame_done), 0);
    chk_le();
    cyc(3); reset = 1'b0; cyc(2);
    for (int x = 7; x < H; x++) pix((x + 3) & 3, 1'b0);
    hs();
    for (int y = 4; y < V; y++) line(y, H, 1'b0);
    cyc(8);
    chk("post_rst_fd", fd_seen, exp_fd);
    chk("post_rst_fd_lit", fd_seen, 4);
    chk("post_rst_wr", wr_cnt, 311);
    chk("post_rst_busy", int'(busy), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
